// File: rtl/mc_ctrl_logic.sv
// Multi-cycle control unit for an RV32I(+M) core: instruction register, decode
// of datapath selects, and the FETCH/DECODE/EXEC/MULDIV/MEM/WB/HALT/TRAP FSM.
module mc_ctrl_logic #(
    parameter bit         ENABLE_M      = 1'b1,
    parameter bit         MEM_HANDSHAKE = 1'b1,
    parameter logic [6:0] HALT_OPCODE   = 7'b1111111
) (
    input  logic        Clk,
    input  logic        Rst_N,
    input  logic [31:0] Instruction,
    input  logic        Instr_Valid,
    input  logic        Branch_Equal,
    input  logic        Branch_Less_Than,
    input  logic        Mem_Ready,
    input  logic        MulDiv_Done,
    output logic        IR_Wr_En,
    output logic        PC_Wr_En,
    output logic        Reg_Wr_En,
    output logic        Store_Word_En,
    output logic        Read_Ctrl,
    output logic        MulDiv_Start,
    output logic        PC_Sel,
    output logic        ALU_Input_A_Sel,
    output logic        ALU_Input_B_Sel,
    output logic        Branch_Un_Sel,
    output logic [3:0]  ALU_Opcode,
    output logic [2:0]  MUL_Opcode,
    output logic [1:0]  Reg_WB_Sel,
    output logic [1:0]  Imm_Gen_Sel,
    output logic [2:0]  Lw_Sw_OP,
    output logic        Halted,
    output logic        Illegal_Instr
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MULDIV = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_TRAP   = 3'd7;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_M    = 4'd10;

    logic [2:0]  state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        md_busy_q, md_busy_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7_alt, f7_m;
    logic       ir_unused;

    assign opcode    = ir_q[6:0];
    assign funct3    = ir_q[14:12];
    assign f7_alt    = ir_q[30];
    assign f7_m      = ir_q[25];
    assign ir_unused = ^{ir_q[31], ir_q[29:26], ir_q[24:15], ir_q[11:7]};

    logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
    logic is_load, is_store, is_opimm, is_op, is_m;

    assign is_lui    = (opcode == OP_LUI);
    assign is_auipc  = (opcode == OP_AUIPC);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_opimm  = (opcode == OP_IMM);
    assign is_op     = (opcode == OP_REG);
    assign is_m      = is_op && f7_m && ENABLE_M;

    logic is_halt, is_illegal, br_taken, mem_ready;

    assign is_halt   = (opcode == HALT_OPCODE);
    assign mem_ready = MEM_HANDSHAKE ? Mem_Ready : 1'b1;

    always_comb begin
        is_illegal = 1'b0;
        case (opcode)
            OP_REG:    is_illegal = f7_m && !ENABLE_M;
            OP_LOAD:   is_illegal = (funct3 inside {3'b011, 3'b110, 3'b111});
            OP_STORE:  is_illegal = (funct3 >= 3'b011);
            OP_BRANCH: is_illegal = (funct3[2:1] == 2'b01);
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM: is_illegal = 1'b0;
            default:   is_illegal = 1'b1;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:         br_taken = Branch_Equal;
            3'b001:         br_taken = !Branch_Equal;
            3'b100, 3'b110: br_taken = Branch_Less_Than;
            3'b101, 3'b111: br_taken = !Branch_Less_Than;
            default:        br_taken = 1'b0;
        endcase
    end

    // Datapath selects depend only on the held IR, so they stay stable until retire.
    always_comb begin
        ALU_Opcode = ALU_ADD;
        if (is_m) begin
            ALU_Opcode = ALU_M;
        end else if (is_op || is_opimm) begin
            case (funct3)
                3'b000:  ALU_Opcode = (is_op && f7_alt) ? ALU_SUB : ALU_ADD;
                3'b001:  ALU_Opcode = ALU_SLL;
                3'b010:  ALU_Opcode = ALU_SLT;
                3'b011:  ALU_Opcode = ALU_SLTU;
                3'b100:  ALU_Opcode = ALU_XOR;
                3'b101:  ALU_Opcode = f7_alt ? ALU_SRA : ALU_SRL;
                3'b110:  ALU_Opcode = ALU_OR;
                default: ALU_Opcode = ALU_AND;
            endcase
        end

        Lw_Sw_OP = 3'd0;
        if (is_load) begin
            case (funct3)
                3'b001:  Lw_Sw_OP = 3'd1;
                3'b010:  Lw_Sw_OP = 3'd2;
                3'b100:  Lw_Sw_OP = 3'd3;
                3'b101:  Lw_Sw_OP = 3'd4;
                default: Lw_Sw_OP = 3'd0;
            endcase
        end else if (is_store) begin
            case (funct3)
                3'b001:  Lw_Sw_OP = 3'd6;
                3'b010:  Lw_Sw_OP = 3'd7;
                default: Lw_Sw_OP = 3'd5;
            endcase
        end

        Imm_Gen_Sel = 2'b00;
        if (is_store)                           Imm_Gen_Sel = 2'b01;
        else if (is_branch)                     Imm_Gen_Sel = 2'b10;
        else if (is_jal || is_lui || is_auipc)  Imm_Gen_Sel = 2'b11;

        Reg_WB_Sel = 2'b00;
        if (is_jal || is_jalr)                               Reg_WB_Sel = 2'b10;
        else if (is_op || is_opimm || is_lui || is_auipc)    Reg_WB_Sel = 2'b01;

        MUL_Opcode      = is_m ? funct3 : 3'b000;
        ALU_Input_A_Sel = is_branch || is_jal || is_auipc;
        ALU_Input_B_Sel = is_opimm || is_load || is_store || is_branch ||
                          is_jal || is_jalr || is_lui || is_auipc;
        Branch_Un_Sel   = is_branch && (funct3[2:1] == 2'b11);
        PC_Sel          = is_branch ? br_taken : (is_jal || is_jalr);
    end

    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        md_busy_d     = 1'b0;
        IR_Wr_En      = 1'b0;
        PC_Wr_En      = 1'b0;
        Reg_Wr_En     = 1'b0;
        Store_Word_En = 1'b0;
        Read_Ctrl     = 1'b0;
        MulDiv_Start  = 1'b0;
        case (state_q)
            S_FETCH: begin
                // Qualified by reset so IR_Wr_En is low while Rst_N is asserted.
                if (Instr_Valid && Rst_N) begin
                    IR_Wr_En = 1'b1;
                    ir_d     = Instruction;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_halt)         state_d = S_HALT;
                else if (is_illegal) state_d = S_TRAP;
                else                 state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_branch) begin
                    PC_Wr_En = 1'b1;
                    state_d  = S_FETCH;
                end else if (is_m) begin
                    state_d = S_MULDIV;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MULDIV: begin
                MulDiv_Start = !md_busy_q;
                if (MulDiv_Done) state_d = S_WB;
                else             md_busy_d = 1'b1;
            end
            S_MEM: begin
                Read_Ctrl     = is_load;
                Store_Word_En = !is_load;
                if (mem_ready) begin
                    if (is_load) begin
                        state_d = S_WB;
                    end else begin
                        PC_Wr_En = 1'b1;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_WB: begin
                Reg_Wr_En = 1'b1;
                PC_Wr_En  = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = state_q;
        endcase
    end

    assign Halted        = (state_q == S_HALT);
    assign Illegal_Instr = (state_q == S_TRAP);

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            md_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            md_busy_q <= md_busy_d;
        end
    end

endmodule

// File: tb/tb_mc_ctrl_logic.sv
// Self-checking bench for mc_ctrl_logic: directed scenarios followed by random
// instructions, checked cycle by cycle against a per-class timing/decode model.
module tb_mc_ctrl_logic;

    logic        Clk = 1'b0;
    logic        Rst_N;
    logic [31:0] Instruction;
    logic        Instr_Valid, Branch_Equal, Branch_Less_Than, Mem_Ready, MulDiv_Done;

    logic IR_Wr_En, PC_Wr_En, Reg_Wr_En, Store_Word_En, Read_Ctrl, MulDiv_Start;
    logic PC_Sel, ALU_Input_A_Sel, ALU_Input_B_Sel, Branch_Un_Sel;
    logic [3:0] ALU_Opcode;
    logic [2:0] MUL_Opcode, Lw_Sw_OP;
    logic [1:0] Reg_WB_Sel, Imm_Gen_Sel;
    logic Halted, Illegal_Instr;

    logic nm_IR_Wr_En, nm_PC_Wr_En, nm_Reg_Wr_En, nm_Store_Word_En, nm_Read_Ctrl, nm_MulDiv_Start;
    logic nm_PC_Sel, nm_A_Sel, nm_B_Sel, nm_Un_Sel;
    logic [3:0] nm_ALU_Opcode;
    logic [2:0] nm_MUL_Opcode, nm_Lw_Sw_OP;
    logic [1:0] nm_Reg_WB_Sel, nm_Imm_Gen_Sel;
    logic nm_Halted, nm_Illegal_Instr;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    mc_ctrl_logic dut (
        .Clk(Clk), .Rst_N(Rst_N), .Instruction(Instruction), .Instr_Valid(Instr_Valid),
        .Branch_Equal(Branch_Equal), .Branch_Less_Than(Branch_Less_Than),
        .Mem_Ready(Mem_Ready), .MulDiv_Done(MulDiv_Done),
        .IR_Wr_En(IR_Wr_En), .PC_Wr_En(PC_Wr_En), .Reg_Wr_En(Reg_Wr_En),
        .Store_Word_En(Store_Word_En), .Read_Ctrl(Read_Ctrl), .MulDiv_Start(MulDiv_Start),
        .PC_Sel(PC_Sel), .ALU_Input_A_Sel(ALU_Input_A_Sel), .ALU_Input_B_Sel(ALU_Input_B_Sel),
        .Branch_Un_Sel(Branch_Un_Sel), .ALU_Opcode(ALU_Opcode), .MUL_Opcode(MUL_Opcode),
        .Reg_WB_Sel(Reg_WB_Sel), .Imm_Gen_Sel(Imm_Gen_Sel), .Lw_Sw_OP(Lw_Sw_OP),
        .Halted(Halted), .Illegal_Instr(Illegal_Instr)
    );

    mc_ctrl_logic #(.ENABLE_M(1'b0)) dut_nm (
        .Clk(Clk), .Rst_N(Rst_N), .Instruction(Instruction), .Instr_Valid(Instr_Valid),
        .Branch_Equal(Branch_Equal), .Branch_Less_Than(Branch_Less_Than),
        .Mem_Ready(Mem_Ready), .MulDiv_Done(MulDiv_Done),
        .IR_Wr_En(nm_IR_Wr_En), .PC_Wr_En(nm_PC_Wr_En), .Reg_Wr_En(nm_Reg_Wr_En),
        .Store_Word_En(nm_Store_Word_En), .Read_Ctrl(nm_Read_Ctrl), .MulDiv_Start(nm_MulDiv_Start),
        .PC_Sel(nm_PC_Sel), .ALU_Input_A_Sel(nm_A_Sel), .ALU_Input_B_Sel(nm_B_Sel),
        .Branch_Un_Sel(nm_Un_Sel), .ALU_Opcode(nm_ALU_Opcode), .MUL_Opcode(nm_MUL_Opcode),
        .Reg_WB_Sel(nm_Reg_WB_Sel), .Imm_Gen_Sel(nm_Imm_Gen_Sel), .Lw_Sw_OP(nm_Lw_Sw_OP),
        .Halted(nm_Halted), .Illegal_Instr(nm_Illegal_Instr)
    );

    localparam logic [2:0] C_ALU = 3'd0, C_JUMP = 3'd1, C_LOAD = 3'd2, C_STORE = 3'd3;
    localparam logic [2:0] C_BR = 3'd4, C_MUL = 3'd5, C_HALT = 3'd6, C_ILL = 3'd7;

    typedef struct packed {
        logic [2:0] cls;
        logic [3:0] alu;
        logic [2:0] mul;
        logic [1:0] wb;
        logic [1:0] imm;
        logic       has_imm;
        logic [2:0] ls;
        logic       un;
    } exp_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] strobes();
        return {IR_Wr_En, PC_Wr_En, Reg_Wr_En, Store_Word_En, Read_Ctrl, MulDiv_Start};
    endfunction

    function automatic logic [5:0] nm_strobes();
        return {nm_IR_Wr_En, nm_PC_Wr_En, nm_Reg_Wr_En, nm_Store_Word_En, nm_Read_Ctrl, nm_MulDiv_Start};
    endfunction

    function automatic logic [17:0] sels();
        return {PC_Sel, ALU_Input_A_Sel, ALU_Input_B_Sel, Branch_Un_Sel, ALU_Opcode,
                MUL_Opcode, Reg_WB_Sel, Imm_Gen_Sel, Lw_Sw_OP};
    endfunction

    // Reference decode: instruction class plus the values the selects must show.
    function automatic exp_t model(input logic [31:0] ins);
        exp_t e;
        logic [3:0] base [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        logic [2:0] ldc  [8] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd3, 3'd4, 3'd0, 3'd0};
        int f3 = int'(ins[14:12]);
        e = '0;
        e.has_imm = 1'b1;
        if (ins[6:0] == 7'h7F) begin
            e.cls = C_HALT;
            return e;
        end
        case (ins[6:0])
            7'h33: begin
                e.has_imm = 1'b0;
                e.wb = 2'd1;
                if (ins[25]) begin
                    e.cls = C_MUL; e.alu = 4'd10; e.mul = ins[14:12];
                end else begin
                    e.cls = C_ALU; e.alu = base[f3];
                    if (f3 == 0 && ins[30]) e.alu = 4'd1;
                    if (f3 == 5 && ins[30]) e.alu = 4'd7;
                end
            end
            7'h13: begin
                e.cls = C_ALU; e.alu = base[f3]; e.wb = 2'd1; e.imm = 2'd0;
                if (f3 == 5 && ins[30]) e.alu = 4'd7;
            end
            7'h37, 7'h17: begin e.cls = C_ALU; e.wb = 2'd1; e.imm = 2'd3; end
            7'h6F: begin e.cls = C_JUMP; e.wb = 2'd2; e.imm = 2'd3; end
            7'h67: begin e.cls = C_JUMP; e.wb = 2'd2; e.imm = 2'd0; end
            7'h03: begin
                if (f3 == 3 || f3 >= 6) e.cls = C_ILL;
                else begin e.cls = C_LOAD; e.ls = ldc[f3]; e.wb = 2'd0; e.imm = 2'd0; end
            end
            7'h23: begin
                if (f3 >= 3) e.cls = C_ILL;
                else begin e.cls = C_STORE; e.ls = 3'(5 + f3); e.imm = 2'd1; end
            end
            7'h63: begin
                if (f3 == 2 || f3 == 3) e.cls = C_ILL;
                else begin e.cls = C_BR; e.imm = 2'd2; e.un = (f3 >= 6); end
            end
            default: e.cls = C_ILL;
        endcase
        return e;
    endfunction

    function automatic logic taken(input logic [2:0] f3, input logic eq, input logic lt);
        case (f3)
            3'd0: return eq;
            3'd1: return !eq;
            3'd4, 3'd6: return lt;
            default: return !lt;
        endcase
    endfunction

    // Runs one instruction from a FETCH-state negedge; w = memory or mul/div wait cycles,
    // extra = cycles observed after HALT/TRAP entry. Ends on a negedge back in FETCH.
    task automatic run_instr(input logic [31:0] ins, input int w, input int extra);
        exp_t e = model(ins);
        int lat;
        logic [5:0] es;
        logic legal = (e.cls != C_HALT) && (e.cls != C_ILL);
        case (e.cls)
            C_BR:          lat = 3;
            C_ALU, C_JUMP: lat = 4;
            C_STORE:       lat = 4 + w;
            C_LOAD, C_MUL: lat = 5 + w;
            default:       lat = 2 + extra;
        endcase
        for (int cyc = 0; cyc <= lat; cyc++) begin
            Instr_Valid = (cyc == 0) ? 1'b1 : ((cyc == lat) ? 1'b0 : 1'($urandom_range(0, 1)));
            Instruction = (cyc == 0) ? ins : $urandom();
            if ((e.cls == C_LOAD || e.cls == C_STORE) && cyc >= 3) Mem_Ready = (cyc >= 3 + w);
            else Mem_Ready = 1'($urandom_range(0, 1));
            if (e.cls == C_MUL && cyc >= 3) MulDiv_Done = (cyc >= 3 + w);
            else MulDiv_Done = 1'($urandom_range(0, 1));
            #1;
            es = '0;
            if (cyc == 0) es[5] = 1'b1;
            case (e.cls)
                C_BR:          if (cyc == 2) es[4] = 1'b1;
                C_ALU, C_JUMP: if (cyc == 3) es[4:3] = 2'b11;
                C_LOAD: begin
                    if (cyc >= 3 && cyc <= 3 + w) es[1] = 1'b1;
                    if (cyc == 4 + w) es[4:3] = 2'b11;
                end
                C_STORE: begin
                    if (cyc >= 3 && cyc <= 3 + w) es[2] = 1'b1;
                    if (cyc == 3 + w) es[4] = 1'b1;
                end
                C_MUL: begin
                    if (cyc == 3) es[0] = 1'b1;
                    if (cyc == 4 + w) es[4:3] = 2'b11;
                end
                default: ;
            endcase
            chk($sformatf("strobes %08h c%0d", ins, cyc), 32'(strobes()), 32'(es));
            if (legal) begin
                chk($sformatf("flags %08h c%0d", ins, cyc), {30'd0, Halted, Illegal_Instr}, 32'd0);
                if (es[4])
                    chk($sformatf("pc_sel %08h c%0d", ins, cyc), 32'(PC_Sel),
                        32'((e.cls == C_BR) ? taken(ins[14:12], Branch_Equal, Branch_Less_Than)
                                             : (e.cls == C_JUMP)));
                if (cyc >= 1 && cyc < lat) begin
                    chk($sformatf("alu_op %08h c%0d", ins, cyc), 32'(ALU_Opcode), 32'(e.alu));
                    chk($sformatf("br_un %08h c%0d", ins, cyc), 32'(Branch_Un_Sel), 32'(e.un));
                    if (e.has_imm)
                        chk($sformatf("imm_sel %08h c%0d", ins, cyc), 32'(Imm_Gen_Sel), 32'(e.imm));
                    if (e.cls inside {C_ALU, C_JUMP, C_LOAD})
                        chk($sformatf("wb_sel %08h c%0d", ins, cyc), 32'(Reg_WB_Sel), 32'(e.wb));
                    if (e.cls inside {C_LOAD, C_STORE})
                        chk($sformatf("lwsw %08h c%0d", ins, cyc), 32'(Lw_Sw_OP), 32'(e.ls));
                    if (e.cls == C_MUL)
                        chk($sformatf("mul_op %08h c%0d", ins, cyc), 32'(MUL_Opcode), 32'(e.mul));
                end
            end else begin
                chk($sformatf("stop_flags %08h c%0d", ins, cyc), {30'd0, Halted, Illegal_Instr},
                    (cyc < 2) ? 32'd0 : ((e.cls == C_HALT) ? 32'd2 : 32'd1));
            end
            @(negedge Clk);
        end
    endtask

    task automatic do_reset();
        Rst_N       = 1'b0;
        Instr_Valid = 1'b1;
        Instruction = $urandom();
        Mem_Ready   = 1'($urandom_range(0, 1));
        MulDiv_Done = 1'($urandom_range(0, 1));
        #1;
        chk("rst_strobes", 32'(strobes()), 32'd0);
        chk("rst_sels", 32'(sels()), 32'd0);
        chk("rst_flags", {30'd0, Halted, Illegal_Instr}, 32'd0);
        chk("rst_nm_strobes", 32'(nm_strobes()), 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Rst_N       = 1'b1;
        Instr_Valid = 1'b0;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] r = $urandom();
        logic [6:0]  op;
        case ($urandom_range(0, 11))
            0:  return {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, r[24:7], 7'h33};
            1:  return {7'h01, r[24:7], 7'h33};
            2:  return {r[31:7], 7'h13};
            3:  return {r[31:7], 7'h03};
            4:  return {r[31:7], 7'h23};
            5:  return {r[31:7], 7'h63};
            6:  return {r[31:7], 7'h37};
            7:  return {r[31:7], 7'h17};
            8:  return {r[31:7], 7'h6F};
            9:  return {r[31:15], 3'b000, r[11:7], 7'h67};
            10: begin
                do op = 7'($urandom_range(0, 127));
                while (op inside {7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63, 7'h7F});
                return {r[31:7], op};
            end
            default: return {r[31:7], 7'h7F};
        endcase
    endfunction

    initial begin
        Rst_N = 1'b0; Instr_Valid = 1'b0; Instruction = '0;
        Branch_Equal = 1'b0; Branch_Less_Than = 1'b0; Mem_Ready = 1'b0; MulDiv_Done = 1'b0;
        @(negedge Clk);
        do_reset();

        run_instr(32'h002081B3, 0, 0);            // add x3,x1,x2
        run_instr(32'h0000A283, 3, 0);            // lw x5,0(x1), three wait cycles
        Branch_Equal = 1'b0;
        run_instr(32'h00209463, 0, 0);            // bne, taken
        Branch_Equal = 1'b1;
        run_instr(32'h00209463, 0, 0);            // bne, not taken

        do_reset();
        run_instr(32'h022081B3, 5, 0);            // mul x3,x1,x2
        chk("nm_trap", 32'(nm_Illegal_Instr), 32'd1);
        chk("nm_trap_strobes", 32'(nm_strobes()), 32'd0);

        run_instr(32'h0000007F, 0, 20);           // halt
        do_reset();

        // Store stalled in MEM, then reset asserted between clock edges.
        Instr_Valid = 1'b1; Instruction = 32'h0020A023; Mem_Ready = 1'b0;
        @(negedge Clk);
        Instr_Valid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        #1;
        chk("st_hold", 32'(Store_Word_En), 32'd1);
        Rst_N = 1'b0;
        #1;
        chk("st_drop", 32'(strobes()), 32'd0);
        @(negedge Clk);
        Rst_N = 1'b1;
        #1;
        chk("st_idle", 32'(strobes()), 32'd0);
        @(negedge Clk);
        run_instr(32'h002081B3, 0, 0);

        for (int i = 0; i < 80; i++) begin
            logic [31:0] ins = gen_instr();
            exp_t e = model(ins);
            Branch_Equal     = 1'($urandom_range(0, 1));
            Branch_Less_Than = 1'($urandom_range(0, 1));
            run_instr(ins, int'($urandom_range(0, 4)), 3);
            if (e.cls == C_HALT || e.cls == C_ILL) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mc_ctrl_logic.md
MC_CTRL_LOGIC -- requirements
Module: mc_ctrl_logic

Interface
REQ-001 SHALL have parameter ENABLE_M, default 1, meaning RV32M decode on; when 0, funct7[0]=1 R-type is illegal.
REQ-002 SHALL have parameter MEM_HANDSHAKE, default 1, meaning MEM waits on Mem_Ready; when 0, Mem_Ready is ignored and treated as 1.
REQ-003 SHALL have parameter HALT_OPCODE, default 7'b1111111, meaning the opcode that halts the core.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 SHALL provide these ports (name  direction  width  meaning):
- Clk  in  1  clock, rising edge.
- Rst_N  in  1  asynchronous active-low reset.
- Instruction  in  32  fetched instruction.
- Instr_Valid  in  1  Instruction valid.
- Branch_Equal, Branch_Less_Than  in  1 each  comparator results.
- Mem_Ready  in  1  data memory access complete.
- MulDiv_Done  in  1  multiply/divide unit result ready.
- IR_Wr_En, PC_Wr_En, Reg_Wr_En, Store_Word_En, Read_Ctrl, MulDiv_Start  out  1 each  strobes.
- PC_Sel, ALU_Input_A_Sel, ALU_Input_B_Sel, Branch_Un_Sel  out  1 each  mux selects.
- ALU_Opcode  out  4  ALU operation.
- MUL_Opcode  out  3  M funct3.
- Reg_WB_Sel  out  2  writeback source: 00 mem, 01 ALU, 10 PC+4.
- Imm_Gen_Sel  out  2  immediate type: 00 I, 01 S, 10 B, 11 J/U.
- Lw_Sw_OP  out  3  LB..SW code 0..7.
- Halted  out  1  core halted.
- Illegal_Instr  out  1  trap flag.

Function
REQ-006 SHALL implement FSM states FETCH, DECODE, EXEC, MULDIV, MEM, WB, HALT, TRAP.
REQ-007 FETCH: SHALL stay in FETCH while Instr_Valid=0; when Instr_Valid=1, SHALL pulse IR_Wr_En, capture Instruction into an internal IR, and go to DECODE.
REQ-008 DECODE (1 cycle): on HALT_OPCODE -> HALT; on illegal opcode/funct3 -> TRAP; otherwise -> EXEC.
REQ-009 Illegal encodings SHALL be:
- unknown opcode;
- load funct3 011/110/111;
- store funct3 >= 011;
- branch funct3 010/011;
- M-type with ENABLE_M=0.
REQ-010 All mux selects, ALU_Opcode, MUL_Opcode, Lw_Sw_OP and Imm_Gen_Sel SHALL derive combinationally from IR and be held stable from DECODE until the instruction retires.
REQ-011 ALU_Opcode encodings SHALL be: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, M 10.
- SUB/SRA are selected by funct7[5]; OP-IMM never yields SUB.
- Load, store, branch, JAL, JALR, LUI and AUIPC use ADD.
REQ-012 EXEC transitions SHALL be:
- R/OP-IMM/LUI/AUIPC/JAL/JALR -> WB.
- M-type -> MULDIV.
- Load/store -> MEM.
- Branch: pulse PC_Wr_En, PC_Sel = taken, -> FETCH.
REQ-013 Branch taken SHALL be: BEQ Eq; BNE !Eq; BLT/BLTU Lt; BGE/BGEU !Lt; Branch_Un_Sel=1 for BLTU/BGEU only.
REQ-014 MULDIV: SHALL pulse MulDiv_Start in the first cycle only, wait for MulDiv_Done=1, then -> WB; MulDiv_Done in the start cycle SHALL be accepted.
REQ-015 MEM: Read_Ctrl (load) or Store_Word_En (store) SHALL be held high until the cycle with Mem_Ready=1.
- Load then -> WB.
- Store pulses PC_Wr_En in that cycle -> FETCH.
REQ-016 WB (1 cycle): SHALL pulse Reg_Wr_En and PC_Wr_En, with PC_Sel=1 for JAL/JALR, else 0, -> FETCH.
REQ-017 Minimum latency Instr_Valid-to-next-FETCH SHALL be: branch 3, ALU 4, store 4, load 5, M-type 5 cycles.
REQ-018 HALT: SHALL keep Halted=1 and all strobes 0 until reset.
REQ-019 TRAP: SHALL keep Illegal_Instr=1 and all strobes 0 until reset.
REQ-020 Strobes SHALL be 0 in every state not listed for them; no strobe SHALL ever be asserted twice for one instruction except the held Read_Ctrl/Store_Word_En.

Reset
REQ-021 Rst_N=0 SHALL asynchronously force state FETCH, IR=0, all outputs 0, Halted=0, Illegal_Instr=0.
REQ-022 Reset mid-MEM or mid-MULDIV SHALL drop Store_Word_En/Read_Ctrl immediately without waiting for the clock; on release, fetch resumes on the first edge with Instr_Valid=1.

Verification
REQ-023 Bench SHALL cover: add x3,x1,x2 (0x002081B3), Instr_Valid=1 -> IR_Wr_En cycle 0, ALU_Opcode=0, Reg_WB_Sel=01, Reg_Wr_En+PC_Wr_En pulse at cycle 3.
REQ-024 Bench SHALL cover: lw (funct3 010), Mem_Ready low 3 cycles -> Read_Ctrl high 4 cycles, Lw_Sw_OP=2, Reg_WB_Sel=00, one Reg_Wr_En afterward.
REQ-025 Bench SHALL cover: bne with Branch_Equal=0 -> PC_Sel=1, PC_Wr_En at cycle 2, no Reg_Wr_En; with Branch_Equal=1 -> PC_Sel=0.
REQ-026 Bench SHALL cover: mul (funct7=0000001), MulDiv_Done after 5 cycles -> single MulDiv_Start, ALU_Opcode=10, MUL_Opcode=000; with ENABLE_M=0 -> Illegal_Instr=1.
REQ-027 Bench SHALL cover: 0x0000007F -> Halted=1 after DECODE, strobes 0 for 20 cycles.
REQ-028 Bench SHALL cover: Rst_N low mid-store -> Store_Word_En 0 before next edge, state FETCH.
